voq_switch_rr: RTL and testbench
================================

VOQ_SWITCH_RR -- requirements
Module: voq_switch_rr

Interface
REQ-001 Parameter PORT_NUB, default 4, port count; SHALL be a power of 2, >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, payload bits per port.
REQ-003 Parameter DEPTH, default 16, entries per output FIFO; SHALL be a power of 2, >= 4.
REQ-004 Parameter ALM_FULL_TH, default 2, almost-full margin; SHALL be < DEPTH.
REQ-005 Derived widths: W_SEL = log2(PORT_NUB); W_CNT = log2(DEPTH)+1.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 in_valid  in  PORT_NUB  per-input cell valid.
REQ-009 in_dest  in  PORT_NUB*W_SEL  per-input destination port.
REQ-010 in_data  in  PORT_NUB*DATA_WIDTH  per-input payload.
REQ-011 in_ready  out  PORT_NUB  per-input accept.
REQ-012 out_valid  out  PORT_NUB  per-output head cell present.
REQ-013 out_data  out  PORT_NUB*DATA_WIDTH  per-output head payload.
REQ-014 out_src  out  PORT_NUB*W_SEL  per-output head source port.
REQ-015 out_ready  in  PORT_NUB  per-output consumer accept.
REQ-016 alm_full  out  PORT_NUB  per-output FIFO almost full.
REQ-017 stat_cnt  out  PORT_NUB*32  per-output delivered count (SWITCH_STATS_EN only).

Function
REQ-018 Input i requests output j when in_valid[i] and in_dest[i]==j; transfer occurs when in_valid[i] and in_ready[i] are both high.
REQ-019 Each output j SHALL own a round-robin arbiter with pointer rr_j; grant = first requester at or after rr_j (modulo PORT_NUB), only when count_j < DEPTH.
REQ-020 After a grant to input g, rr_j SHALL become (g+1) mod PORT_NUB; with no grant, rr_j holds.
REQ-021 in_ready[i] SHALL be combinational: high only when output in_dest[i] grants i this cycle; in_ready is allowed to depend on in_valid.
REQ-022 At most one cell per output per cycle; distinct outputs accept in parallel (up to PORT_NUB cells/cycle).
REQ-023 Accepted cell {source index, data} SHALL be written to output FIFO j in the same cycle.
REQ-024 FIFO is first-word-fall-through: out_valid[j] = (count_j != 0); out_data/out_src show the head entry.
REQ-025 Latency: a cell accepted in cycle N into an empty FIFO SHALL appear on out_valid in cycle N+1.
REQ-026 Pop on out_valid[j] && out_ready[j]; out_ready with empty FIFO is ignored.
REQ-027 Full (count_j == DEPTH): no grant, even if a pop occurs the same cycle.
REQ-028 Simultaneous push and pop with count_j < DEPTH: count unchanged, order preserved.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; count SHALL stay in 0..DEPTH.
REQ-030 alm_full[j] = (count_j >= DEPTH - ALM_FULL_TH), registered-count based.
REQ-031 Cells within one input-to-output pair SHALL never reorder.

Reset
REQ-032 Asserting rst_n low SHALL clear every count, FIFO pointer, and rr_j to 0, and stat_cnt to 0, without waiting for clk.
REQ-033 During reset: out_valid = 0, in_ready = 0, alm_full = 0. Cells held mid-FIFO are discarded.

Configuration
REQ-034 Macro SWITCH_STATS_EN defined: stat_cnt[j] increments by 1 per pop on output j and wraps from 2^32-1 to 0.
REQ-035 Macro SWITCH_STATS_EN undefined: stat_cnt port and counters are absent; all other behaviour is identical.

Structure
REQ-036 Shared package voq_switch_pkg SHALL hold W_SEL/W_CNT derivation functions and the FIFO entry struct {src, data}.
REQ-037 Sub-module rr_arbiter (PORT_NUB-wide request/grant, pointer update) SHALL be instantiated once per output. The FIFO SHALL stay inline.

Verification
REQ-038 Setup: PORT_NUB=4, DATA_WIDTH=8, DEPTH=16, ALM_FULL_TH=2. Single cell: in0 dest2 data 0xA5 -> in_ready[0]=1 same cycle; next cycle out_valid[2]=1, out_data=0xA5, out_src=0.
REQ-039 Contention: in0..in3 all dest1 and held valid, out_ready[1]=1 -> grants in order 0,1,2,3,0; out_src sequence is 0,1,2,3.
REQ-040 Full: out_ready[3]=0, 20 cells to dest3 -> 16 accepted, alm_full[3]=1 from count 14, in_ready low afterwards. One pop while in_valid is high -> no grant that cycle; next cycle one grant.
REQ-041 Parallel: in0->1, in1->0, in2->3, in3->2 in one cycle -> all four in_ready high; each output holds one entry.
REQ-042 Reset mid-run: 5 cells queued on out0, rst_n pulsed low between clock edges -> out_valid=0 immediately; after release, rr restarts at input 0.
REQ-043 SWITCH_STATS_EN: 100 pops on out2 -> stat_cnt[2]=100; counter preset near 2^32-1 -> wraps to 0.

Source files
------------

// File: rtl/voq_switch_pkg.sv
// Shared definitions for the VOQ switch: width derivation helpers and the
// output-FIFO entry layout. The entry struct is sized for the largest
// supported configuration (up to 256 ports, up to 64-bit payload); the
// switch stores only the low bits it needs and the rest stay constant zero.
package voq_switch_pkg;

  localparam int unsigned SRC_W_MAX  = 8;
  localparam int unsigned DATA_W_MAX = 64;

  // Select width for an n-port switch (n is a power of 2).
  function automatic int unsigned f_w_sel(input int unsigned n);
    return unsigned'($clog2(n));
  endfunction

  // Occupancy counter width for a FIFO of the given depth (holds 0..depth).
  function automatic int unsigned f_w_cnt(input int unsigned depth);
    return unsigned'($clog2(depth)) + 1;
  endfunction

  typedef struct packed {
    logic [SRC_W_MAX-1:0]  src;
    logic [DATA_W_MAX-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one switch output.
// Ports:
//   clk, rst_n    clock, async active-low reset (pointer clears to 0)
//   i_req[N]      request vector, one bit per input
//   i_en          arbitration enable (low while the output FIFO is full)
//   o_grant_c[N]  combinational one-hot grant
//   o_gidx_c      combinational index of the granted input
//   o_gvalid_c    combinational "a grant was issued"
// The search starts at the pointer; after a grant the pointer moves to the
// input just past the winner, otherwise it holds.
module rr_arbiter
  import voq_switch_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = f_w_sel(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_grant_c,
  output logic [W-1:0] o_gidx_c,
  output logic         o_gvalid_c
);

  logic [W-1:0] r_ptr;
  logic [W-1:0] w_idx;

  // First requester at or after the pointer, wrapping through the power-of-2 index.
  always_comb begin
    o_grant_c  = '0;
    o_gidx_c   = '0;
    o_gvalid_c = 1'b0;
    w_idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = r_ptr + W'(k);
      if (i_en && !o_gvalid_c && i_req[w_idx]) begin
        o_gvalid_c = 1'b1;
        o_gidx_c   = w_idx;
      end
    end
    if (o_gvalid_c) o_grant_c[o_gidx_c] = 1'b1;
  end

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_ptr <= '0;
    else if (o_gvalid_c) r_ptr <= o_gidx_c + W'(1);
  end

endmodule

// File: rtl/voq_switch_rr.sv
// PORT_NUB x PORT_NUB cell switch with one round-robin arbiter and one
// first-word-fall-through FIFO per output.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_valid     per-input cell valid
//   in_dest      per-input destination port (W_SEL bits each)
//   in_data      per-input payload (DATA_WIDTH bits each)
//   in_ready     per-input accept, combinational (grant from its destination)
//   out_valid    per-output head cell present
//   out_data     per-output head payload
//   out_src      per-output head source port
//   out_ready    per-output consumer accept
//   alm_full     per-output FIFO occupancy >= DEPTH-ALM_FULL_TH
//   stat_cnt     per-output 32-bit delivered-cell counter (SWITCH_STATS_EN)
// Optional feature: define SWITCH_STATS_EN to add stat_cnt and its counters.
// Supported range: PORT_NUB <= 256, DATA_WIDTH <= 64.
module voq_switch_rr
  import voq_switch_pkg::*;
#(
  parameter int unsigned PORT_NUB    = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALM_FULL_TH = 2,
  localparam int unsigned W_SEL = f_w_sel(PORT_NUB),
  localparam int unsigned W_CNT = f_w_cnt(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORT_NUB-1:0]            in_valid,
  input  logic [PORT_NUB*W_SEL-1:0]      in_dest,
  input  logic [PORT_NUB*DATA_WIDTH-1:0] in_data,
  output logic [PORT_NUB-1:0]            in_ready,
  output logic [PORT_NUB-1:0]            out_valid,
  output logic [PORT_NUB*DATA_WIDTH-1:0] out_data,
  output logic [PORT_NUB*W_SEL-1:0]      out_src,
  input  logic [PORT_NUB-1:0]            out_ready,
  output logic [PORT_NUB-1:0]            alm_full
`ifdef SWITCH_STATS_EN
  ,
  output logic [PORT_NUB*32-1:0]         stat_cnt
`endif
);

  localparam int unsigned W_PTR = W_CNT - 1;
  localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(DEPTH);
  localparam logic [W_CNT-1:0] CNT_ALM  = W_CNT'(DEPTH - ALM_FULL_TH);

  logic [PORT_NUB*PORT_NUB-1:0] w_grant_flat;

  // An input can only be granted by the output it addresses, so OR-ing all
  // grant columns gives its ready. Held low while in reset.
  always_comb begin
    in_ready = '0;
    for (int unsigned j = 0; j < PORT_NUB; j++) begin
      in_ready = in_ready | w_grant_flat[j*PORT_NUB +: PORT_NUB];
    end
    if (!rst_n) in_ready = '0;
  end

  for (genvar j = 0; j < PORT_NUB; j++) begin : g_out
    logic [PORT_NUB-1:0] w_req;
    logic [PORT_NUB-1:0] w_grant;
    logic [W_SEL-1:0]    w_gsrc;
    logic                w_push;
    logic                w_pop;
    fifo_entry_t         w_wr_entry;
    fifo_entry_t         w_head;
    logic                w_unused_head;
    fifo_entry_t         r_mem [DEPTH];
    logic [W_PTR-1:0]    r_wr_ptr;
    logic [W_PTR-1:0]    r_rd_ptr;
    logic [W_CNT-1:0]    r_cnt;

    // Inputs addressing this output.
    always_comb begin
      w_req = '0;
      for (int unsigned i = 0; i < PORT_NUB; i++) begin
        w_req[i] = in_valid[i] && (in_dest[i*W_SEL +: W_SEL] == W_SEL'(j));
      end
    end

    // Full blocks the grant even when a pop happens in the same cycle.
    rr_arbiter #(.N(PORT_NUB)) u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (w_req),
      .i_en       (r_cnt != CNT_FULL),
      .o_grant_c  (w_grant),
      .o_gidx_c   (w_gsrc),
      .o_gvalid_c (w_push)
    );

    assign w_grant_flat[j*PORT_NUB +: PORT_NUB] = w_grant;

    // Winner's payload tagged with its source index.
    always_comb begin
      w_wr_entry     = '0;
      w_wr_entry.src = SRC_W_MAX'(w_gsrc);
      for (int unsigned i = 0; i < PORT_NUB; i++) begin
        if (w_gsrc == W_SEL'(i)) w_wr_entry.data = DATA_W_MAX'(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end

    assign w_pop = (r_cnt != '0) && out_ready[j];

    // Storage, no reset: contents are qualified by the count.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
    end

    // Pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + W_PTR'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + W_PTR'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + W_CNT'(1);
          2'b01:   r_cnt <= r_cnt - W_CNT'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign out_valid[j]                          = (r_cnt != '0);
    assign out_data[j*DATA_WIDTH +: DATA_WIDTH]  = DATA_WIDTH'(w_head.data);
    assign out_src[j*W_SEL +: W_SEL]             = W_SEL'(w_head.src);
    assign alm_full[j]                           = (r_cnt >= CNT_ALM);
    // Upper entry bits beyond this configuration are never presented.
    assign w_unused_head = ^w_head;

`ifdef SWITCH_STATS_EN
    logic [31:0] r_stat;

    // Delivered-cell counter, wraps at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_stat <= '0;
      else if (w_pop) r_stat <= r_stat + 32'd1;
    end

    assign stat_cnt[j*32 +: 32] = r_stat;
`endif
  end

endmodule

// File: tb/tb_voq_switch_rr.sv
module tb_voq_switch_rr;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int ALM   = 2;
  localparam int WS    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      in_valid;
  logic [N*WS-1:0]   in_dest;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_ready;
  logic [N-1:0]      out_valid;
  logic [N*DW-1:0]   out_data;
  logic [N*WS-1:0]   out_src;
  logic [N-1:0]      out_ready;
  logic [N-1:0]      alm_full;
`ifdef SWITCH_STATS_EN
  logic [N*32-1:0]   stat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  voq_switch_rr #(.PORT_NUB(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALM_FULL_TH(ALM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .alm_full  (alm_full)
`ifdef SWITCH_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  // Reference model: one queue of cells and one rotating priority per output.
  typedef struct { int src; int data; } cell_t;
  cell_t mq [N][$];
  int    mrr [N];

  function automatic int dest_of(int i);
    return int'(in_dest[i*WS +: WS]);
  endfunction

  function automatic logic [N-1:0] mdl_ready();
    logic [N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      if (mq[j].size() < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          int i = (mrr[j] + k) % N;
          if (in_valid[i] && dest_of(i) == j) begin
            r[i] = 1'b1;
            break;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic void mdl_commit();
    logic [N-1:0] r;
    r = mdl_ready();
    for (int j = 0; j < N; j++)
      if (mq[j].size() != 0 && out_ready[j]) void'(mq[j].pop_front());
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        int j = dest_of(i);
        mq[j].push_back('{src: i, data: int'(in_data[i*DW +: DW])});
        mrr[j] = (i + 1) % N;
      end
    end
  endfunction

  function automatic void mdl_reset();
    for (int j = 0; j < N; j++) begin
      mq[j].delete();
      mrr[j] = 0;
    end
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = '0;
    out_ready = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mdl_reset();
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = '1;
    repeat (DEPTH + 2) tick();
    out_ready = '0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = '1;
    in_dest  = 8'h00;
    #3;
    n_checks++;
    if (out_valid !== '0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    n_checks++;
    if (in_ready !== '0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    n_checks++;
    if (alm_full !== '0) begin n_fail++; $display("FAIL reset_alm_full: got %b expected 0000", alm_full); end
    tick();
    rst_n    = 1'b1;
    in_valid = '0;
    mdl_reset();
    tick();
  endtask

  task automatic test_single_cell();
    in_valid = 4'b0001;
    in_dest  = 8'h02;
    in_data  = 32'h000000A5;
    #3;
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", in_ready); end
    tick();
    in_valid = '0;
    #3;
    n_checks++;
    if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL single_out_valid: got %b expected 0100", out_valid); end
    n_checks++;
    if (out_data[2*DW +: DW] !== 8'hA5) begin n_fail++; $display("FAIL single_out_data: got %h expected a5", out_data[2*DW +: DW]); end
    n_checks++;
    if (out_src[2*WS +: WS] !== 2'd0) begin n_fail++; $display("FAIL single_out_src: got %0d expected 0", out_src[2*WS +: WS]); end
    drain();
  endtask

  task automatic test_contention();
    in_valid  = 4'b1111;
    in_dest   = 8'b01010101;
    in_data   = 32'h33221100;
    out_ready = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = N'(1 << (c % N));
      #3;
      n_checks++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL contention_grant c=%0d: got %b expected %b", c, in_ready, exp_rdy); end
      if (c >= 1) begin
        n_checks++;
        if (out_valid[1] !== 1'b1 || out_src[1*WS +: WS] !== WS'(c - 1))
          begin n_fail++; $display("FAIL contention_src c=%0d: got v=%b src=%0d expected v=1 src=%0d", c, out_valid[1], out_src[1*WS +: WS], c - 1); end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full();
    in_dest   = 8'h03;
    out_ready = '0;
    for (int c = 0; c < 20; c++) begin
      int cnt;
      in_valid = 4'b0001;
      in_data  = 32'(c);
      cnt = (c < DEPTH) ? c : DEPTH;
      #3;
      n_checks++;
      if (in_ready[0] !== (c < DEPTH)) begin n_fail++; $display("FAIL full_accept c=%0d: got %b expected %b", c, in_ready[0], c < DEPTH); end
      n_checks++;
      if (alm_full[3] !== (cnt >= DEPTH - ALM)) begin n_fail++; $display("FAIL full_alm c=%0d: got %b expected %b", c, alm_full[3], cnt >= DEPTH - ALM); end
      tick();
    end
    // Pop while full: no grant that cycle even though a slot frees up.
    in_data   = 32'hEE;
    out_ready = 4'b1000;
    #3;
    n_checks++;
    if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL full_pop_nogrant: got %b expected 0", in_ready[0]); end
    tick();
    out_ready = '0;
    #3;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL full_regrant: got %b expected 1", in_ready[0]); end
    tick();
    in_valid  = '0;
    out_ready = 4'b1000;
    for (int k = 0; k < DEPTH; k++) begin
      logic [DW-1:0] exp_d;
      exp_d = (k < DEPTH - 1) ? DW'(k + 1) : 8'hEE;
      #3;
      n_checks++;
      if (out_valid[3] !== 1'b1 || out_data[3*DW +: DW] !== exp_d)
        begin n_fail++; $display("FAIL full_order k=%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid[3], out_data[3*DW +: DW], exp_d); end
      tick();
    end
    #3;
    n_checks++;
    if (out_valid[3] !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", out_valid[3]); end
    tick();
    drain();
  endtask

  task automatic test_parallel();
    in_valid  = 4'b1111;
    in_dest   = 8'b10110001;
    in_data   = 32'h43322110;
    out_ready = '0;
    #3;
    n_checks++;
    if (in_ready !== 4'b1111) begin n_fail++; $display("FAIL parallel_ready: got %b expected 1111", in_ready); end
    tick();
    in_valid = '0;
    tick();
    #3;
    n_checks++;
    if (out_valid !== 4'b1111) begin n_fail++; $display("FAIL parallel_valid: got %b expected 1111", out_valid); end
    n_checks++;
    if (out_src !== 8'b10110001) begin n_fail++; $display("FAIL parallel_src: got %b expected 10110001", out_src); end
    n_checks++;
    if (out_data !== 32'h32431021) begin n_fail++; $display("FAIL parallel_data: got %h expected 32431021", out_data); end
    tick();
    out_ready = '1;
    tick();
    #3;
    n_checks++;
    if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL parallel_one_each: got %b expected 0000", out_valid); end
    tick();
    drain();
  endtask

  task automatic test_reset_midrun();
    // Five cells from input 2 leave out0's pointer at 3.
    in_valid  = 4'b0100;
    in_dest   = 8'h00;
    in_data   = 32'h00550000;
    out_ready = '0;
    repeat (5) tick();
    in_valid = '0;
    #2;
    n_checks++;
    if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL midrun_queued: got %b expected 1", out_valid[0]); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== '0) begin n_fail++; $display("FAIL midrun_async_valid: got %b expected 0000", out_valid); end
    n_checks++;
    if (alm_full !== '0) begin n_fail++; $display("FAIL midrun_alm: got %b expected 0000", alm_full); end
    in_valid = '1;
    #1;
    n_checks++;
    if (in_ready !== '0) begin n_fail++; $display("FAIL midrun_ready: got %b expected 0000", in_ready); end
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    n_checks++;
    if (out_valid !== '0) begin n_fail++; $display("FAIL midrun_discard: got %b expected 0000", out_valid); end
    in_valid = 4'b1111;
    #2;
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL midrun_rr_restart: got %b expected 0001", in_ready); end
    tick();
    drain();
  endtask

`ifdef SWITCH_STATS_EN
  task automatic test_stats();
    apply_reset();
    in_valid  = 4'b1000;
    in_dest   = 8'b10000000;
    out_ready = 4'b0100;
    repeat (100) tick();
    in_valid = '0;
    repeat (2) tick();
    n_checks++;
    if (stat_cnt[2*32 +: 32] !== 32'd100) begin n_fail++; $display("FAIL stats_out2: got %0d expected 100", stat_cnt[2*32 +: 32]); end
    n_checks++;
    if (stat_cnt[1*32 +: 32] !== 32'd0) begin n_fail++; $display("FAIL stats_out1: got %0d expected 0", stat_cnt[1*32 +: 32]); end
    drain();
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] exp_rdy;
      int thr;
      thr = ((c / 200) % 2 == 1) ? 1 : 3;
      in_valid = N'($urandom);
      in_dest  = (N*WS)'($urandom);
      in_data  = (N*DW)'($urandom);
      for (int j = 0; j < N; j++) out_ready[j] = ($urandom_range(0, 3) < thr);
      #3;
      exp_rdy = mdl_ready();
      n_checks++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, in_ready, exp_rdy); end
      for (int j = 0; j < N; j++) begin
        int sz = mq[j].size();
        n_checks++;
        if (out_valid[j] !== (sz != 0)) begin n_fail++; $display("FAIL rand_valid c=%0d out%0d: got %b expected %b", c, j, out_valid[j], sz != 0); end
        n_checks++;
        if (alm_full[j] !== (sz >= DEPTH - ALM)) begin n_fail++; $display("FAIL rand_alm c=%0d out%0d: got %b expected %b", c, j, alm_full[j], sz >= DEPTH - ALM); end
        if (sz != 0) begin
          n_checks++;
          if (int'(out_data[j*DW +: DW]) != mq[j][0].data || int'(out_src[j*WS +: WS]) != mq[j][0].src)
            begin n_fail++; $display("FAIL rand_head c=%0d out%0d: got d=%h s=%0d expected d=%h s=%0d", c, j, out_data[j*DW +: DW], out_src[j*WS +: WS], mq[j][0].data, mq[j][0].src); end
        end
      end
      @(posedge clk);
      mdl_commit();
      #1;
    end
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_dest   = '0;
    in_data   = '0;
    out_ready = '0;
    tick();
    test_reset();
    test_single_cell();
    test_contention();
    test_full();
    test_parallel();
    test_reset_midrun();
`ifdef SWITCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
